// File: rtl/logic_arbiter.sv
// logic_arbiter: round-robin arbiter feeding a one-deep registered bitwise ALU result; res_zero port present when LOGIC_ARB_ZFLAG_EN is defined
module logic_arbiter #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*WIDTH-1:0]    req_a,
  input  logic [NREQ*WIDTH-1:0]    req_b,
  input  logic [NREQ*2-1:0]        req_op,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_data,
  output logic [$clog2(NREQ)-1:0]  res_id
`ifdef LOGIC_ARB_ZFLAG_EN
  , output logic                   res_zero
`endif
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic {IDLE, FULL} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, gidx, res_id_q, res_id_d;
  logic [WIDTH-1:0] res_data_q, res_data_d, a, b, alu;
  logic [1:0] op;
  logic found, xfer;
  int k;
  always_comb begin
    found = 1'b0;
    gidx = '0;
    k = 0;
    for (int i = 0; i < NREQ; i++) begin
      k = int'(ptr_q) + i;
      k = k >= NREQ ? k - NREQ : k;
      if (!found && req_valid[IW'(k)]) begin
        found = 1'b1;
        gidx = IW'(k);
      end
    end
  end
  always_comb begin
    a = req_a[gidx*WIDTH +: WIDTH];
    b = req_b[gidx*WIDTH +: WIDTH];
    op = req_op[gidx*2 +: 2];
    alu = op == 2'b00 ? a | b : op == 2'b01 ? a & b : op == 2'b10 ? a ^ b : ~a;
    req_ready = (rst_n && found && (state_q == IDLE || res_ready)) ? NREQ'(1) << gidx : '0;
    xfer = |req_ready;
    state_d = xfer ? FULL : res_ready ? IDLE : state_q;
    ptr_d = xfer ? (gidx == IW'(NREQ-1) ? '0 : gidx + 1'b1) : ptr_q;
    res_data_d = xfer ? alu : res_data_q;
    res_id_d = xfer ? gidx : res_id_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      res_data_q <= '0;
      res_id_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      res_data_q <= res_data_d;
      res_id_q <= res_id_d;
    end
  end
  assign res_valid = state_q == FULL;
  assign res_data = res_data_q;
  assign res_id = res_id_q;
`ifdef LOGIC_ARB_ZFLAG_EN
  logic zero_q, zero_d;
  assign zero_d = xfer ? ~|alu : zero_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) zero_q <= 1'b0;
    else zero_q <= zero_d;
  end
  assign res_zero = zero_q;
`endif
endmodule

// File: tb/tb_logic_arbiter.sv
// tb_logic_arbiter: directed self-checking bench for logic_arbiter
module tb_logic_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] req_valid, req_ready;
  logic [63:0] req_a, req_b;
  logic [7:0] req_op;
  logic res_valid, res_ready;
  logic [15:0] res_data;
  logic [1:0] res_id;
`ifdef LOGIC_ARB_ZFLAG_EN
  logic res_zero;
`endif
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  logic_arbiter #(.WIDTH(16), .NREQ(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id)
`ifdef LOGIC_ARB_ZFLAG_EN
    , .res_zero(res_zero)
`endif
  );
  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    req_a[i*16 +: 16] = a;
    req_b[i*16 +: 16] = b;
    req_op[i*2 +: 2] = op;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    res_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 4'b1111;
    res_ready = 1'b1;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
    checks++; if (res_data !== 16'h0000) begin errors++; $display("FAIL reset_res_data got %h want 0000", res_data); end
    checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL reset_res_id got %0d want 0", res_id); end
    req_valid = '0;
    res_ready = 1'b0;
    rst_n = 1'b1;
  endtask
  task automatic test_basic();
    @(negedge clk);
    set_req(0, 16'h00F0, 16'h0F00, 2'b00);
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL basic_grant got %b want 0001", req_ready); end
    @(negedge clk);
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", res_valid); end
    checks++; if (res_data !== 16'h0FF0) begin errors++; $display("FAIL basic_data got %h want 0ff0", res_data); end
    checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL basic_id got %0d want 0", res_id); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL basic_full_stall got %b want 0000", req_ready); end
    req_valid = '0;
    res_ready = 1'b1;
    @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL basic_consume got %b want 0", res_valid); end
  endtask
  task automatic test_opcodes();
    logic [15:0] exp [4] = '{16'hFFAA, 16'hAA00, 16'h55AA, 16'h5555};
    for (int k = 0; k < 4; k++) begin
      set_req(1, 16'hAAAA, 16'hFF00, 2'(k));
      req_valid = 4'b0010;
      res_ready = 1'b1;
      @(negedge clk);
      checks++; if (res_data !== exp[k]) begin errors++; $display("FAIL opcode_%0d got %h want %h", k, res_data, exp[k]); end
      checks++; if (res_id !== 2'd1) begin errors++; $display("FAIL opcode_id_%0d got %0d want 1", k, res_id); end
    end
    req_valid = '0;
    @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL opcode_drain got %b want 0", res_valid); end
  endtask
  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 16'(i), 16'h0000, 2'b00);
    req_valid = 4'b1111;
    res_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rr_first got %b want 0001", req_ready); end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL rr_valid_%0d got %b want 1", c, res_valid); end
      checks++; if (res_id !== 2'(c % 4)) begin errors++; $display("FAIL rr_id_%0d got %0d want %0d", c, res_id, c % 4); end
      checks++; if (res_data !== 16'(c % 4)) begin errors++; $display("FAIL rr_data_%0d got %h want %h", c, res_data, 16'(c % 4)); end
      checks++; if (req_ready !== 4'(1 << ((c + 1) % 4))) begin errors++; $display("FAIL rr_ready_%0d got %b want %b", c, req_ready, 4'(1 << ((c + 1) % 4))); end
    end
  endtask
  task automatic test_back_to_back();
    res_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_stall got %b want 0000", req_ready); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready_%0d got %b want 0000", c, req_ready); end
      checks++; if (res_valid !== 1'b1 || res_id !== 2'd3 || res_data !== 16'h0003) begin errors++; $display("FAIL bp_hold_%0d got v%b id%0d %h want v1 id3 0003", c, res_valid, res_id, res_data); end
    end
    res_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_release got %b want 0001", req_ready); end
    @(negedge clk);
    checks++; if (res_valid !== 1'b1 || res_id !== 2'd0) begin errors++; $display("FAIL bp_nobubble got v%b id%0d want v1 id0", res_valid, res_id); end
  endtask
  task automatic test_reset_mid();
    set_req(0, 16'h1234, 16'h0000, 2'b00);
    req_valid = 4'b1001;
    res_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", res_valid); end
    checks++; if (res_data !== 16'h0000 || res_id !== 2'd0) begin errors++; $display("FAIL rstmid_regs got %h id%0d want 0000 id0", res_data, res_id); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rstmid_ready got %b want 0000", req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rstmid_ptr got %b want 0001", req_ready); end
    @(negedge clk);
    checks++; if (res_valid !== 1'b1 || res_id !== 2'd0 || res_data !== 16'h1234) begin errors++; $display("FAIL rstmid_grant got v%b id%0d %h want v1 id0 1234", res_valid, res_id, res_data); end
  endtask
  task automatic test_idle_hold();
    req_valid = '0;
    res_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b want 0", res_valid); end
    req_valid = 4'b0011;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL idle_ptr_hold got %b want 0010", req_ready); end
    @(negedge clk);
    req_valid = '0;
  endtask
`ifdef LOGIC_ARB_ZFLAG_EN
  task automatic test_zflag();
    set_req(2, 16'h00FF, 16'hFF00, 2'b01);
    req_valid = 4'b0100;
    res_ready = 1'b1;
    @(negedge clk);
    checks++; if (res_data !== 16'h0000 || res_zero !== 1'b1) begin errors++; $display("FAIL zflag got %h z%b want 0000 z1", res_data, res_zero); end
    req_valid = '0;
    @(negedge clk);
  endtask
`endif
  initial begin
    test_reset();
    test_basic();
    test_opcodes();
    test_round_robin();
    test_back_to_back();
    test_reset_mid();
    test_idle_hold();
`ifdef LOGIC_ARB_ZFLAG_EN
    test_zflag();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/logic_arbiter.md
LOGIC_ARBITER -- requirements
Module: logic_arbiter

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the operand and result width in bits.
REQ-002 Parameter NREQ, default 4, SHALL set the number of requesters; the legal range is 2..8.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit, SHALL be the asynchronous active-low reset.
REQ-005 Port req_valid, input, NREQ bits: bit i high means requester i presents an operation.
REQ-006 Port req_ready, output, NREQ bits: bit i high means requester i's operation is accepted this cycle.
REQ-007 Port req_a, input, NREQ*WIDTH bits: operand A of requester i, in slice [i*WIDTH +: WIDTH].
REQ-008 Port req_b, input, NREQ*WIDTH bits: operand B, packed the same as req_a.
REQ-009 Port req_op, input, NREQ*2 bits: opcode of requester i, in slice [i*2 +: 2].
REQ-010 Port res_valid, output, 1 bit: the result register holds an unconsumed result.
REQ-011 Port res_ready, input, 1 bit: the consumer accepts the result this cycle.
REQ-012 Port res_data, output, WIDTH bits: the registered result.
REQ-013 Port res_id, output, clog2(NREQ) bits: index of the requester that owns res_data.

Function
REQ-014 Opcodes SHALL be: 00 = A|B, 01 = A&B, 10 = A^B, 11 = ~A (B ignored); all operations are bitwise over WIDTH bits.
REQ-015 The FSM SHALL have exactly two states, IDLE (result register empty) and FULL (result register occupied); res_valid is high exactly in FULL.
REQ-016 At most one req_ready bit SHALL be high in any cycle; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-017 Grant SHALL be round-robin: search starts at ptr, proceeds upward modulo NREQ, and selects the first asserted req_valid bit.
REQ-018 After a transfer from requester g, ptr SHALL become (g+1) mod NREQ; without a transfer, ptr SHALL hold.
REQ-019 req_ready[g] SHALL be high for the selected g when the state is IDLE, or when the state is FULL and res_ready is high (back-to-back); otherwise all req_ready bits SHALL be low.
REQ-020 Latency SHALL be one cycle: a transfer at edge N makes res_valid, res_data and res_id valid after edge N.
REQ-021 A consume (res_valid and res_ready high) with no transfer in the same cycle SHALL move the FSM FULL->IDLE.
REQ-022 A consume with a simultaneous transfer SHALL keep the FSM in FULL, load the new result, and produce no bubble.
REQ-023 While res_valid is high and res_ready is low, res_data and res_id SHALL hold stable and no transfer SHALL occur.
REQ-024 Deassertion of req_valid[i] by a requester not granted SHALL be legal and SHALL NOT affect state; req_ready SHALL depend combinationally on req_valid, state, ptr and res_ready only.
REQ-025 With all req_valid bits low, no transfer SHALL occur and ptr SHALL hold.

Reset
REQ-026 Asserting rst_n low SHALL asynchronously force: state IDLE, res_valid 0, res_data 0, res_id 0, ptr 0, and (if compiled in) res_zero 0.
REQ-027 Reset mid-operation SHALL discard any held result without a consume; req_ready SHALL be all zero while rst_n is low.
REQ-028 Deassertion of rst_n SHALL be taken synchronously; the first grant occurs no earlier than the first rising edge after deassertion.

Configuration
REQ-029 When macro LOGIC_ARB_ZFLAG_EN is defined, an output res_zero (1 bit) SHALL exist, registered alongside res_data, high when the result is all zeros.
REQ-030 When LOGIC_ARB_ZFLAG_EN is undefined, port res_zero and its register SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-031 Reset, then req_valid=0001, a=0x00F0, b=0x0F00, op=00 on requester 0 -> one cycle later res_valid=1, res_data=0x0FF0, res_id=0.
REQ-032 All four requesters valid continuously and res_ready=1 -> grants go 0,1,2,3,0,... one per cycle, with no bubbles.
REQ-033 Result held with res_ready=0 for 5 cycles while req_valid=1111 -> req_ready=0000, res_data stable; res_ready=1 -> back-to-back transfer in the same cycle.
REQ-034 Opcodes on a=0xAAAA, b=0xFF00 -> OR 0xFFAA, AND 0xAA00, XOR 0x55AA, NOT 0x5555.
REQ-035 rst_n pulsed low while FULL with res_ready=0 -> res_valid=0 immediately; ptr=0, so next grant goes to the lowest valid requester.
REQ-036 With LOGIC_ARB_ZFLAG_EN, a=0x00FF, b=0xFF00, op=01 -> res_data=0x0000 and res_zero=1.
